// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_ctrl
//  Description : Time-multiplexed scan controller sharing one external
//                hex-to-7-segment decoder across NUM_DIGITS common-anode
//                digits, with a valid/ready-loaded value/blank register file,
//                leading-zero suppression and an all-off gap between digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
    input  logic [3:0]                    wr_value,
    input  logic                          wr_blank,
    input  logic                          lz_suppress,
    output logic [3:0]                    dec_val,
    input  logic [6:0]                    dec_seg,
    output logic [6:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         digit_en_n
);

    localparam int c_idx_w   = $clog2(NUM_DIGITS);
    localparam int c_cnt_max = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [0:0] c_st_gap   = 1'b0;
    localparam logic [0:0] c_st_drive = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_idx_w-1:0] w_idx_nxt;
    logic [3:0]         r_value [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_blank;
    logic [6:0]         r_seg;
    logic [NUM_DIGITS-1:0] w_zero_from;
    logic [NUM_DIGITS-1:0] w_en_n;
    logic               w_load;
    logic               w_suppressed;
    logic               w_wr_fire;

    // The load cycle is the last gap cycle; writes are held off so a load never tears.
    assign w_load    = (r_state == c_st_gap) && (r_cnt == c_cnt_w'(GAP_CYCLES - 1));
    assign wr_ready  = ~w_load;
    assign w_wr_fire = wr_valid & wr_ready;

    assign dec_val    = r_value[r_idx];
    assign seg_out    = r_seg;
    assign digit_en_n = w_en_n;

    // w_zero_from[i] is set when digit i and every more significant digit hold zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero_from
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign w_zero_from[gi] = (r_value[gi] == 4'h0);
            end else begin : g_lower
                assign w_zero_from[gi] = w_zero_from[gi+1] & (r_value[gi] == 4'h0);
            end
        end
    endgenerate

    // Digit 0 is never zero-suppressed so an all-zero display still shows "0".
    assign w_suppressed = r_blank[r_idx] |
                          (lz_suppress & (r_idx != '0) & w_zero_from[r_idx]);

    // Scan state, dwell/gap counter and digit index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_gap;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: GAP holds all digits off, DRIVE lights digit r_idx.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        w_idx_nxt   = r_idx;
        case (r_state)
            c_st_gap: begin
                if (r_cnt == c_cnt_w'(GAP_CYCLES - 1)) begin
                    w_state_nxt = c_st_drive;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (r_cnt == c_cnt_w'(DWELL_CYCLES - 1)) begin
                    w_state_nxt = c_st_gap;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == c_idx_w'(NUM_DIGITS - 1)) ? '0 : r_idx + c_idx_w'(1);
                end
            end
        endcase
    end

    // Active-low digit enables derived from the scan state.
    always_comb begin
        w_en_n = '1;
        if (r_state == c_st_drive) begin
            w_en_n[r_idx] = 1'b0;
        end
    end

    // Register file; indices with no matching digit complete the handshake but store nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_value[i] <= 4'h0;
            end
            r_blank <= '1;
        end else if (w_wr_fire) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_digit == c_idx_w'(i)) begin
                    r_value[i] <= wr_value;
                    r_blank[i] <= wr_blank;
                end
            end
        end
    end

    // Segment pattern is captured once per digit visit, on the load cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg <= 7'h7F;
        end else if (w_load) begin
            r_seg <= w_suppressed ? 7'h7F : dec_seg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_scan_ctrl
//  Description : Directed self-checking bench for hex_scan_ctrl
//                (NUM_DIGITS=4, DWELL_CYCLES=4, GAP_CYCLES=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_ctrl;

    localparam int c_n     = 4;
    localparam int c_dwell = 4;
    localparam int c_gap   = 2;
    localparam int c_slot  = c_dwell + c_gap;
    localparam int c_per   = c_n * c_slot;

    logic       clk;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_digit;
    logic [3:0] wr_value;
    logic       wr_blank;
    logic       lz_suppress;
    logic [3:0] dec_val;
    logic [6:0] dec_seg;
    logic [6:0] seg_out;
    logic [3:0] digit_en_n;

    int         n_checks;
    int         n_fail;
    int         k;
    logic [6:0] exp_seg [4];

    hex_scan_ctrl #(
        .NUM_DIGITS   (c_n),
        .DWELL_CYCLES (c_dwell),
        .GAP_CYCLES   (c_gap)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_digit    (wr_digit),
        .wr_value    (wr_value),
        .wr_blank    (wr_blank),
        .lz_suppress (lz_suppress),
        .dec_val     (dec_val),
        .dec_seg     (dec_seg),
        .seg_out     (seg_out),
        .digit_en_n  (digit_en_n)
    );

    // External decoder model: standard active-low gfedcba hex table.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
        endcase
    endfunction

    assign dec_seg = hex7(dec_val);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Expected digit enables k cycles after reset release.
    function automatic logic [3:0] exp_en(input int kk);
        int p;
        p = kk % c_slot;
        if (p < c_gap) exp_en = 4'b1111;
        else           exp_en = ~(4'b0001 << ((kk / c_slot) % c_n));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic align();
        while (k % c_per != 0) step();
    endtask

    task automatic step_to(input int phase);
        while (k % c_per != phase) step();
    endtask

    task automatic do_write(input logic [1:0] d, input logic [3:0] v, input logic b);
        int tries;
        wr_valid = 1'b1;
        wr_digit = d;
        wr_value = v;
        wr_blank = b;
        tries    = 0;
        while (!wr_ready && tries < 8) begin
            step();
            tries++;
        end
        if (!wr_ready) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
    endtask

    // Two scan periods straight after reset release with every digit blanked.
    task automatic blank_scan();
        for (int i = 0; i < 2 * c_per; i++) begin
            check("blank_en", 32'(digit_en_n), 32'(exp_en(k)));
            check("blank_seg", 32'(seg_out), 32'h7F);
            check("blank_rdy", 32'(wr_ready), 32'((k % c_slot) != c_gap - 1));
            check("blank_dec", 32'(dec_val), 32'h0);
            step();
        end
    endtask

    // One full period from a period boundary, checking enables and dwell segments.
    task automatic scan_period(input string tag);
        for (int i = 0; i < c_per; i++) begin
            check({tag, "_en"}, 32'(digit_en_n), 32'(exp_en(k)));
            if ((k % c_slot) >= c_gap)
                check({tag, "_seg"}, 32'(seg_out), 32'(exp_seg[(k / c_slot) % c_n]));
            step();
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        k           = 0;
        reset_n     = 1'b0;
        wr_valid    = 1'b0;
        wr_digit    = 2'd0;
        wr_value    = 4'h0;
        wr_blank    = 1'b0;
        lz_suppress = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_en", 32'(digit_en_n), 32'hF);
        check("rst_rdy", 32'(wr_ready), 32'd1);
        reset_n = 1'b1;
        k = 0;

        // 1: blank scan after reset
        blank_scan();

        // 2: digits 1,2,3,4 unblanked
        do_write(2'd0, 4'h1, 1'b0);
        do_write(2'd1, 4'h2, 1'b0);
        do_write(2'd2, 4'h3, 1'b0);
        do_write(2'd3, 4'h4, 1'b0);
        align();
        exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
        scan_period("t2");

        // 3: leading-zero suppression with d3..d0 = 0,0,5,0
        do_write(2'd0, 4'h0, 1'b0);
        do_write(2'd1, 4'h5, 1'b0);
        do_write(2'd2, 4'h0, 1'b0);
        do_write(2'd3, 4'h0, 1'b0);
        lz_suppress = 1'b1;
        align();
        exp_seg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        scan_period("t3lz");
        lz_suppress = 1'b0;
        exp_seg = '{7'h40, 7'h12, 7'h40, 7'h40};
        scan_period("t3nolz");

        // 4: request raised on the digit-1 load cycle
        step_to(c_slot + c_gap - 1);
        wr_valid = 1'b1;
        wr_digit = 2'd1;
        wr_value = 4'h7;
        wr_blank = 1'b0;
        check("t4_rdy_load", 32'(wr_ready), 32'd0);
        step();
        check("t4_rdy_after", 32'(wr_ready), 32'd1);
        check("t4_old_seg", 32'(seg_out), 32'h12);
        step();
        wr_valid = 1'b0;
        check("t4_old_seg2", 32'(seg_out), 32'h12);
        align();
        exp_seg = '{7'h40, 7'h78, 7'h40, 7'h40};
        scan_period("t4");

        // 5: write the digit currently being driven
        step_to(2 * c_slot + c_gap);
        check("t5_pre_seg", 32'(seg_out), 32'h40);
        do_write(2'd2, 4'hA, 1'b0);
        while ((k % c_slot) >= c_gap) begin
            check("t5_hold_seg", 32'(seg_out), 32'h40);
            step();
        end
        align();
        exp_seg = '{7'h40, 7'h78, 7'h08, 7'h40};
        scan_period("t5a");
        do_write(2'd2, 4'hA, 1'b1);
        align();
        exp_seg = '{7'h40, 7'h78, 7'h7F, 7'h40};
        scan_period("t5b");

        // 6: asynchronous reset in the middle of a dwell (digit 0, cnt=2)
        step_to(c_gap + 2);
        check("t6_pre_en", 32'(digit_en_n), 32'hE);
        check("t6_pre_seg", 32'(seg_out), 32'h40);
        reset_n = 1'b0;
        #1;
        check("t6_async_seg", 32'(seg_out), 32'h7F);
        check("t6_async_en", 32'(digit_en_n), 32'hF);
        check("t6_async_rdy", 32'(wr_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        k = 0;
        blank_scan();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
